// File: rtl/hash_core_arbiter.sv
// hash_core_arbiter
// Round-robin scheduler sharing one SHA-1 compression core among NREQ
// requesters. A requester is locked onto the core for its whole message.
// Each 512-bit block is sequenced as start -> word feed -> done. Only the
// final chaining value of a message is returned, tagged with its owner id.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester word handshake
//   req_data          NREQ packed words, requester i at [i*DW +: DW]
//   req_last          final-block marker, sampled on the block's last word
//   core_start/first  one-cycle block start; first selects the SHA-1 IV
//   core_wvalid/wdata/wready  word stream into the core
//   core_done/digest  block complete, chaining value valid with done
//   rsp_valid/id/digest/ready final digest handshake
//   err               sticky: core_done observed outside WAIT
module hash_core_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int DW          = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic                core_start,
  output logic                core_first,
  output logic                core_wvalid,
  output logic [DW-1:0]       core_wdata,
  input  logic                core_wready,
  input  logic                core_done,
  input  logic [159:0]        core_digest,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [159:0]        rsp_digest,
  input  logic                rsp_ready,
  output logic                err
);

  localparam int CW = $clog2(BLOCK_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] r_ptr;
  logic           r_first;
  logic           r_last;
  logic           r_err;
  logic [CW-1:0]  r_cnt;
  logic [159:0]   r_digest;

  logic           w_hit;
  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_idx;
  logic           w_gvalid;
  logic [DW-1:0]  w_gdata;
  logic           w_xfer;
  logic           w_blk_end;

  assign w_gvalid  = req_valid[r_grant];
  assign w_gdata   = req_data[r_grant*DW +: DW];
  assign w_xfer    = (r_state == S_FEED) && w_gvalid && core_wready;
  assign w_blk_end = w_xfer && (r_cnt == CW'(BLOCK_WORDS - 1));
  assign err       = r_err;

  // Round-robin search from ptr+1. Walking the offsets from farthest to
  // nearest lets the nearest requesting id overwrite the pick last.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_hit  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hit) w_next = S_START;
      S_START: w_next = S_FEED;
      S_FEED:  if (w_blk_end) w_next = S_WAIT;
      S_WAIT:  if (core_done) w_next = r_last ? S_RESP : S_START;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from state only, so reset zeroes them at once.
  always_comb begin
    core_start  = 1'b0;
    core_first  = 1'b0;
    core_wvalid = 1'b0;
    core_wdata  = '0;
    req_ready   = '0;
    rsp_valid   = 1'b0;
    rsp_id      = '0;
    rsp_digest  = '0;
    case (r_state)
      S_START: begin
        core_start = 1'b1;
        core_first = r_first;
      end
      S_FEED: begin
        core_wvalid        = w_gvalid;
        core_wdata         = w_gdata;
        req_ready[r_grant] = core_wready;
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        rsp_id     = r_grant;
        rsp_digest = r_digest;
      end
      default: ;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= IDW'(NREQ - 1);
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (core_done && (r_state != S_WAIT)) r_err <= 1'b1;
      case (r_state)
        S_IDLE: if (w_hit) begin
          r_grant <= w_pick;
          r_first <= 1'b1;
        end
        S_START: r_cnt <= '0;
        S_FEED: if (w_xfer) begin
          // Rolls to zero only after the block's final word.
          r_cnt <= r_cnt + CW'(1);
          if (w_blk_end) r_last <= req_last[r_grant];
        end
        S_WAIT: if (core_done && !r_last) r_first <= 1'b0;
        S_RESP: if (rsp_ready) r_ptr <= r_grant;
        default: ;
      endcase
    end
  end

  // Chaining value capture; only presented on rsp while in RESP.
  always_ff @(posedge clk) begin
    if ((r_state == S_WAIT) && core_done) r_digest <= core_digest;
  end

endmodule

// File: tb/tb_hash_core_arbiter.sv
// tb_hash_core_arbiter
// Directed bench for hash_core_arbiter: single two-block message, core
// backpressure, requester gap, response stall, protocol error, reset
// mid-block and round-robin fairness.
module tb_hash_core_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         core_start;
  logic         core_first;
  logic         core_wvalid;
  logic [31:0]  core_wdata;
  logic         core_wready;
  logic         core_done;
  logic [159:0] core_digest;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [159:0] rsp_digest;
  logic         rsp_ready;
  logic         err;

  int n_chk = 0;
  int n_err = 0;

  hash_core_arbiter #(.NREQ(4), .IDW(2), .DW(32), .BLOCK_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .core_start(core_start), .core_first(core_first),
    .core_wvalid(core_wvalid), .core_wdata(core_wdata),
    .core_wready(core_wready), .core_done(core_done),
    .core_digest(core_digest),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_digest(rsp_digest),
    .rsp_ready(rsp_ready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In START: check the pulse, then advance into FEED.
  task automatic start_now(input logic ef);
    #1;
    chk("start", 192'(core_start), 192'(1));
    chk("start_first", 192'(core_first), 192'(ef));
    chk("start_rdy", 192'(req_ready), 192'(0));
    tick();
  endtask

  // Feed up to stop_at words from requester id. mode 1 toggles core_wready
  // (ready on odd cycles); gap_at drops req_valid for 3 cycles when that word
  // is next; err_at pulses core_done on that feed cycle.
  task automatic send_block(input int id, input logic [31:0] base, input logic lastf,
                            input int mode, input int gap_at, input int err_at,
                            input int stop_at, input logic keep, output int cycles);
    int   words;
    int   cyc;
    int   gap;
    logic gapdone;
    logic xfer;
    logic [3:0] er;
    words = 0; cyc = 0; gap = 0; gapdone = 1'b0;
    er = 4'b0001 << id;
    while (words < stop_at && cyc < 200) begin
      if (words == gap_at && !gapdone) begin
        gap = 3;
        gapdone = 1'b1;
      end
      req_valid[id]          = (gap == 0);
      req_data[id*32 +: 32]  = base + 32'(words);
      req_last[id]           = (words == 15) ? lastf : (words == 5);
      core_wready            = (mode == 1) ? cyc[0] : 1'b1;
      core_done              = (cyc == err_at);
      core_digest            = {5{32'hDEAD_BEEF}};
      #1;
      xfer = core_wvalid && core_wready;
      if (xfer) begin
        chk("wdata", 192'(core_wdata), 192'(base + 32'(words)));
        chk("wready_mask", 192'(req_ready), 192'(er));
      end
      if (gap > 0) gap--;
      tick();
      if (xfer) words++;
      cyc++;
    end
    if (words < stop_at) chk("feed_timeout", 192'(words), 192'(stop_at));
    core_done    = 1'b0;
    core_wready  = 1'b0;
    req_last[id] = 1'b0;
    if (!keep) req_valid[id] = 1'b0;
    cycles = cyc;
  endtask

  // In WAIT: hold two cycles, then pulse core_done with digest d.
  task automatic finish_block(input logic [159:0] d, input logic lastf, input logic [1:0] eid);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wait_hold", 192'({rsp_valid, core_start}), 192'(0));
      tick();
    end
    core_done   = 1'b1;
    core_digest = d;
    tick();
    core_done   = 1'b0;
    core_digest = '1;
    #1;
    if (lastf) begin
      chk("rsp_valid", 192'(rsp_valid), 192'(1));
      chk("rsp_id", 192'(rsp_id), 192'(eid));
      chk("rsp_digest", 192'(rsp_digest), 192'(d));
    end else begin
      chk("next_start", 192'(core_start), 192'(1));
      chk("next_first", 192'(core_first), 192'(0));
      chk("no_mid_rsp", 192'(rsp_valid), 192'(0));
      tick();
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("rsp_drop", 192'(rsp_valid), 192'(0));
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_start"}, 192'(core_start), 192'(0));
    chk({tag, "_first"}, 192'(core_first), 192'(0));
    chk({tag, "_wvalid"}, 192'(core_wvalid), 192'(0));
    chk({tag, "_wdata"}, 192'(core_wdata), 192'(0));
    chk({tag, "_rdy"}, 192'(req_ready), 192'(0));
    chk({tag, "_rvalid"}, 192'(rsp_valid), 192'(0));
    chk({tag, "_rid"}, 192'(rsp_id), 192'(0));
    chk({tag, "_rdig"}, 192'(rsp_digest), 192'(0));
    chk({tag, "_err"}, 192'(err), 192'(0));
  endtask

  initial begin
    int cyc;
    logic [159:0] d;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    core_wready = 1'b0; core_done = 1'b0; core_digest = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    rst_n = 1'b1;
    tick();

    // Two-block message from requester 2
    req_valid[2] = 1'b1;
    tick();
    start_now(1'b1);
    send_block(2, 32'h2000_0000, 1'b0, 0, -1, -1, 16, 1'b1, cyc);
    finish_block({5{32'h1111_0001}}, 1'b0, 2'd2);
    send_block(2, 32'h2100_0000, 1'b1, 0, -1, -1, 16, 1'b0, cyc);
    finish_block({5{32'h2222_0002}}, 1'b1, 2'd2);
    take_rsp();

    // Core backpressure, requester 1
    req_valid[1] = 1'b1;
    tick();
    start_now(1'b1);
    send_block(1, 32'h1000_0000, 1'b1, 1, -1, -1, 16, 1'b0, cyc);
    chk("bp_cycles", 192'(cyc), 192'(32));
    d = {5{32'h3333_0003}};
    finish_block(d, 1'b1, 2'd1);

    // Response stall with requester 0 waiting
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_valid", 192'(rsp_valid), 192'(1));
      chk("stall_digest", 192'(rsp_digest), 192'(d));
      chk("stall_nostart", 192'(core_start), 192'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("post_rsp_idle", 192'({rsp_valid, core_start}), 192'(0));
    tick();
    start_now(1'b1);

    // Requester gap mid-block
    send_block(0, 32'h0000_5000, 1'b1, 0, 7, -1, 16, 1'b1, cyc);
    chk("gap_cycles", 192'(cyc), 192'(19));
    core_wready = 1'b1;
    #1;
    chk("gap_end_wvalid", 192'(core_wvalid), 192'(0));
    chk("gap_end_rdy", 192'(req_ready), 192'(0));
    core_wready = 1'b0;
    req_valid[0] = 1'b0;
    finish_block({5{32'h4444_0004}}, 1'b1, 2'd0);
    take_rsp();

    // core_done during FEED, requester 3
    chk("err_before", 192'(err), 192'(0));
    req_valid[3] = 1'b1;
    tick();
    start_now(1'b1);
    send_block(3, 32'h3000_0000, 1'b1, 0, -1, 4, 16, 1'b0, cyc);
    chk("err_set", 192'(err), 192'(1));
    chk("err_cycles", 192'(cyc), 192'(16));
    finish_block({5{32'h5555_0005}}, 1'b1, 2'd3);
    take_rsp();
    chk("err_sticky", 192'(err), 192'(1));

    // Reset after 7 words of a block
    req_valid[2] = 1'b1;
    tick();
    start_now(1'b1);
    send_block(2, 32'h2200_0000, 1'b1, 0, -1, -1, 7, 1'b1, cyc);
    core_wready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("midrst");
    core_wready = 1'b0;
    req_valid = 4'b1001;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_now(1'b1);
    send_block(0, 32'h0000_7000, 1'b1, 0, -1, -1, 16, 1'b0, cyc);
    req_valid = '0;
    finish_block({5{32'h6666_0006}}, 1'b1, 2'd0);
    take_rsp();

    // Fairness: everyone requesting, 1-block messages
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    tick();
    for (int m = 0; m < 5; m++) begin
      start_now(1'b1);
      send_block(m % 4, 32'hF000_0000 + 32'(m << 8), 1'b1, 0, -1, -1, 16, 1'b1, cyc);
      finish_block({5{32'h7777_0000 + 32'(m)}}, 1'b1, 2'(m % 4));
      take_rsp();
      tick();
    end
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hash_core_arbiter.md
# hash_core_arbiter

Round-robin scheduler that shares one SHA-1 compression core among NREQ netsync requesters. These are push/pull channels that need revision and file hashes checked. Each requester streams a message as whole 512-bit blocks. The arbiter locks the core to one requester for a complete message, sequences the core's start, word feed and done handshakes, and returns the final 160-bit digest tagged with the requester id.

## Interface
- NREQ, 4: number of requesters, 2..8
- IDW, 2: requester id width, equal to clog2(NREQ)
- DW, 32: message word width
- BLOCK_WORDS, 16: words per compression block
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester word valid, one bit per requester
- req_data  in  NREQ*DW  requester words; requester i uses bits [i*DW +: DW]
- req_last  in  NREQ  marks the current block as the message's final block; sampled on the block's last word only
- req_ready  out  NREQ  word accepted, per requester
- core_start  out  1  one-cycle pulse that begins a block
- core_first  out  1  valid with core_start; 1 means load the SHA-1 initial chaining value
- core_wvalid  out  1  word to core valid
- core_wdata  out  DW  word to core
- core_wready  in  1  core accepts the word
- core_done  in  1  one-cycle pulse when the block is compressed
- core_digest  in  160  chaining value; valid while core_done is high
- rsp_valid  out  1  final digest available
- rsp_id  out  IDW  id of the requester that owns the digest
- rsp_digest  out  160  final digest
- rsp_ready  in  1  consumer accepts the digest
- err  out  1  sticky protocol error flag

## Operation
- FSM states: IDLE, START, FEED, WAIT, RESP.
- IDLE:
  - Search req_valid round-robin, starting at ptr+1 mod NREQ.
  - On a hit, register grant=id and first=1, then go to START.
  - With no request, stay in IDLE.
- START:
  - core_start=1 and core_first=first for exactly one cycle.
  - Clear the word counter, then go to FEED.
- FEED:
  - core_wvalid = req_valid[grant]; core_wdata = req_data[grant].
  - req_ready[grant] = core_wready; every other req_ready bit is 0.
  - A word transfers when valid and ready are both high; the counter then increments.
  - On the transfer where the counter equals BLOCK_WORDS-1, latch last = req_last[grant] and go to WAIT.
- WAIT:
  - On core_done, latch core_digest into the digest register.
  - If last=1, go to RESP.
  - Otherwise set first=0 and go to START, keeping the same grant. The message lock holds, so no context save is needed.
- RESP:
  - rsp_valid=1 while rsp_id=grant and rsp_digest=digest register.
  - On rsp_ready, set ptr=grant and go to IDLE.
- Only final digests leave the block; intermediate chaining values are never presented on rsp.
- Error conditions set err, which stays set until reset:
  - core_done seen in any state other than WAIT. The pulse is otherwise ignored.
  - core_wready high outside FEED is harmless and is not an error.
- Word counter width is clog2(BLOCK_WORDS) and it never wraps mid-block.

## Timing
- Values after reset:
  - All outputs are 0, including rsp_id and rsp_digest; err=0.
  - State=IDLE and ptr=NREQ-1, so requester 0 has first priority.
- Reset asserted mid-operation abandons the message immediately. The core is not notified; its next start must carry core_first=1.
- Latency from request to core start: req_valid is sampled in IDLE at edge k, and core_start is high during cycle k+1.
- Feed rate is one word per cycle at best. If req_valid[grant] drops, the counter stalls with no timeout.
- core_done to rsp_valid is 1 cycle when last=1. It is 1 cycle to the next core_start when last=0.
- The rsp_ready handshake leads to IDLE on the next cycle, and arbitration takes that IDLE cycle. There is no combinational bypass, so the minimum gap between consecutive messages is 2 idle cycles of core_start.
- A requester that deasserts req_valid while it holds the grant keeps the lock until its message ends.
- req_last asserted on a non-final word is ignored.

## Test plan
- Single message: requester 2 sends 2 blocks, with req_last=1 on word 15 of block 2.
  - core_start pulses twice: first with core_first=1, then with core_first=0.
  - rsp_id=2 and rsp_digest equals the second core_digest.
  - The first digest is never seen on rsp.
- Fairness: all 4 req_valid held high, each sending 1-block messages. The grant order is 0,1,2,3,0. rsp_id follows the same sequence.
- Backpressure:
  - core_wready toggles every other cycle, so 16 words take 32 cycles.
  - A 3-cycle req_valid gap mid-block gives no word loss, and the counter holds.
- Response stall: rsp_ready is held low for 10 cycles. rsp_valid and rsp_digest stay stable, and no core_start is issued until 2 cycles after rsp_ready.
- Protocol error: a core_done pulse during FEED sets err=1. The FEED word count is unaffected, and err persists until rst_n is asserted.
- Reset mid-block: rst_n is asserted after 7 words of a block.
  - All outputs go to 0 at once.
  - After release, requester 0 and requester 3 both request; requester 0 wins, with core_first=1.
